// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state, size and funct3 definitions for the MEM-stage load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  // Signedness (funct3[2]) is applied downstream by Load_encode, so only the size matters here.
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for sub-word stores and loads, plus the alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_shifted_o,
  output logic        misalign_o
);
  always_comb begin
    be_o = size_i == SZ_B ? 4'b0001 << off_i : size_i == SZ_H ? 4'b0011 << off_i : 4'b1111;
    wdata_rep_o = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_shifted_o = rdata_i >> {off_i, 3'b000};
    misalign_o = (size_i == SZ_H && off_i[0]) || (size_i[1] && off_i != 2'b00);
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage controller issuing one data-bus transaction per load/store,
// stalling the pipeline until it completes, times out, or is rejected as misaligned.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = $clog2(MAX_WAIT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic        lsu_misalign,
  output logic        lsu_timeout,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d, mis_q, mis_d, to_q, to_d;
  logic [1:0]       off_q, off_d;
  logic [29:0]      waddr_q, waddr_d;
  logic [3:0]       be_q, be_d, a_be;
  logic [31:0]      wdata_q, wdata_d, load_q, load_d, a_wdata, a_rdata;
  logic             a_mis, idle;
  assign idle = state_q == IDLE;
  // In IDLE the aligner sees the incoming operands; afterwards the latched offset drives the load shift.
  lsu_align u_align (
    .size_i          (f3_size(lsu_funct3)),
    .off_i           (idle ? lsu_addr[1:0] : off_q),
    .wdata_i         (lsu_wdata),
    .rdata_i         (mem_rdata),
    .be_o            (a_be),
    .wdata_rep_o     (a_wdata),
    .rdata_shifted_o (a_rdata),
    .misalign_o      (a_mis)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mis_d   = mis_q;
    to_d    = to_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    if (state_q == IDLE) begin
      mis_d = 1'b0;
      to_d  = 1'b0;
      if (lsu_valid) begin
        state_d = a_mis ? RESP : REQ;
        mis_d   = a_mis;
        cnt_d   = '0;
        if (!a_mis) begin
          we_d    = lsu_we;
          off_d   = lsu_addr[1:0];
          waddr_d = lsu_addr[31:2];
          be_d    = a_be;
          wdata_d = a_wdata;
        end
      end
    end else if (state_q == REQ) begin
      cnt_d = cnt_q + 1'b1;
      if (mem_ack) begin
        state_d = RESP;
        load_d  = we_q ? load_q : a_rdata;
      end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
        state_d = RESP;
        to_d    = 1'b1;
        load_d  = '0;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      off_q   <= '0;
      waddr_q <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end
  // Bus fields read as zero whenever no request is outstanding.
  assign mem_req      = state_q == REQ;
  assign mem_we       = mem_req & we_q;
  assign mem_addr     = mem_req ? {waddr_q, 2'b00} : '0;
  assign mem_be       = mem_req ? be_q : '0;
  assign mem_wdata    = mem_req ? wdata_q : '0;
  assign lsu_done     = state_q == RESP;
  assign lsu_misalign = lsu_done & mis_q;
  assign lsu_timeout  = lsu_done & to_q;
  assign lsu_stall    = lsu_valid & ~lsu_done;
  assign load_data    = load_q;
endmodule
